// File: rtl/commit_reclaim_8wide.sv
// Retire-side committed map plus reclaim staging FIFO that drains freed tags to the rename free list.
// Optional COMMIT_RECLAIM_STATS_EN adds reclaim/stall/backpressure counters.
module commit_reclaim_8wide #(
    parameter int PHYS_REGS   = 128,
    parameter int ARCH_REGS   = 32,
    parameter int BUF_DEPTH   = 16,
    parameter int DRAIN_WIDTH = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [7:0]                                       retire_valid_i,
    input  logic [7:0][$clog2(ARCH_REGS)-1:0]                retire_rd_arch_i,
    input  logic [7:0][$clog2(PHYS_REGS)-1:0]                retire_rd_phys_i,
    input  logic [7:0][$clog2(PHYS_REGS)-1:0]                retire_old_phys_i,
    output logic                                             retire_ready_o,
    output logic [ARCH_REGS*$clog2(PHYS_REGS)-1:0]           commit_map_o,
    output logic [DRAIN_WIDTH-1:0]                           free_push_valid_o,
    output logic [DRAIN_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]    free_push_phys_o,
    input  logic                                             free_push_ready_i,
    output logic [$clog2(BUF_DEPTH):0]                       buf_count_o
`ifdef COMMIT_RECLAIM_STATS_EN
    ,
    output logic [31:0]                                      stat_reclaimed_o,
    output logic [31:0]                                      stat_stall_o,
    output logic [31:0]                                      stat_backpress_o
`endif
);
    localparam int PW    = $clog2(PHYS_REGS);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BUF_DEPTH-1:0][PW-1:0] fifo;
    logic [ARCH_REGS-1:0][PW-1:0] map;
    logic [PTR_W-1:0]             head, tail;
    logic [CNT_W-1:0]             count;
    logic [7:0]                   live, push;
    logic [7:0][3:0]              offs;
    logic [3:0]                   n_push;
    logic [CNT_W-1:0]             n_drain;
    logic                         pop;

    // Ready only looks at registered occupancy so a full bundle always fits.
    assign retire_ready_o = (count <= CNT_W'(BUF_DEPTH - 8));
    assign commit_map_o   = map;
    assign buf_count_o    = count;

    // Prefix-count the pushing slots so tags land compacted in slot order.
    always_comb begin
        live   = '0;
        push   = '0;
        offs   = '0;
        n_push = '0;
        for (int k = 0; k < 8; k++) begin
            live[k] = retire_valid_i[k] && (retire_rd_arch_i[k] != '0);
            push[k] = retire_ready_o && live[k] && (retire_old_phys_i[k] != '0);
            offs[k] = n_push;
            n_push  = n_push + 4'(push[k]);
        end
    end

    assign n_drain = (count > CNT_W'(DRAIN_WIDTH)) ? CNT_W'(DRAIN_WIDTH) : count;
    assign pop     = free_push_ready_i && (n_drain != '0);

    for (genvar j = 0; j < DRAIN_WIDTH; j++) begin : g_lane
        logic act;
        assign act                  = (CNT_W'(j) < n_drain);
        assign free_push_valid_o[j] = act;
        assign free_push_phys_o[j]  = act ? fifo[head + PTR_W'(j)] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) map[i] <= PW'(i);
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Later slots overwrite earlier ones, so the youngest writer of an arch reg wins.
            for (int k = 0; k < 8; k++) begin
                if (retire_ready_o && live[k]) map[retire_rd_arch_i[k]] <= retire_rd_phys_i[k];
                if (push[k]) fifo[tail + PTR_W'(offs[k])] <= retire_old_phys_i[k];
            end
            tail <= tail + PTR_W'(n_push);
            if (pop) head <= head + PTR_W'(n_drain);
            count <= count + CNT_W'(n_push) - (pop ? n_drain : '0);
        end
    end

`ifdef COMMIT_RECLAIM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reclaimed_o <= '0;
            stat_stall_o     <= '0;
            stat_backpress_o <= '0;
        end else begin
            if (pop) stat_reclaimed_o <= stat_reclaimed_o + 32'(n_drain);
            if ((|retire_valid_i) && !retire_ready_o) stat_stall_o <= stat_stall_o + 32'd1;
            if ((count != '0) && !free_push_ready_i) stat_backpress_o <= stat_backpress_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_commit_reclaim_8wide.sv
// Scoreboard bench for commit_reclaim_8wide: expected tags queued at accept, checked as they drain.
module tb_commit_reclaim_8wide;
    logic             clk = 0;
    logic             rst;
    logic [7:0]       retire_valid_i;
    logic [7:0][4:0]  retire_rd_arch_i;
    logic [7:0][6:0]  retire_rd_phys_i;
    logic [7:0][6:0]  retire_old_phys_i;
    logic             retire_ready_o;
    logic [223:0]     commit_map_o;
    logic [3:0]       free_push_valid_o;
    logic [3:0][6:0]  free_push_phys_o;
    logic             free_push_ready_i;
    logic [4:0]       buf_count_o;
`ifdef COMMIT_RECLAIM_STATS_EN
    logic [31:0]      stat_reclaimed_o, stat_stall_o, stat_backpress_o;
`endif

    commit_reclaim_8wide dut (
        .clk(clk), .rst(rst),
        .retire_valid_i(retire_valid_i), .retire_rd_arch_i(retire_rd_arch_i),
        .retire_rd_phys_i(retire_rd_phys_i), .retire_old_phys_i(retire_old_phys_i),
        .retire_ready_o(retire_ready_o), .commit_map_o(commit_map_o),
        .free_push_valid_o(free_push_valid_o), .free_push_phys_o(free_push_phys_o),
        .free_push_ready_i(free_push_ready_i), .buf_count_o(buf_count_o)
`ifdef COMMIT_RECLAIM_STATS_EN
        , .stat_reclaimed_o(stat_reclaimed_o), .stat_stall_o(stat_stall_o),
        .stat_backpress_o(stat_backpress_o)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         popped = 0;
    bit         mon_en = 0;
    logic [6:0] sb[$];
    logic [6:0] exp_map[32];

    // Drain monitor: checks occupancy and lanes mid-cycle, pops what the next edge will pop.
    always @(negedge clk) begin
        if (mon_en) begin
            int n;
            logic [6:0] e;
            n = (sb.size() > 4) ? 4 : sb.size();
            total++;
            if (buf_count_o !== 5'(sb.size())) begin
                bad++; $display("FAIL count got=%0d exp=%0d", buf_count_o, sb.size());
            end
            total++;
            if (buf_count_o > 5'd16) begin
                bad++; $display("FAIL count_bound got=%0d exp<=16", buf_count_o);
            end
            total++;
            if (retire_ready_o !== (sb.size() <= 8)) begin
                bad++; $display("FAIL ready got=%0b exp=%0b", retire_ready_o, sb.size() <= 8);
            end
            total++;
            if (free_push_valid_o !== 4'((1 << n) - 1)) begin
                bad++; $display("FAIL valid_mask got=%b exp=%b", free_push_valid_o, 4'((1 << n) - 1));
            end
            for (int j = 0; j < 4; j++) begin
                e = (j < n) ? sb[j] : 7'd0;
                total++;
                if (free_push_phys_o[j] !== e) begin
                    bad++; $display("FAIL lane%0d got=%0d exp=%0d", j, free_push_phys_o[j], e);
                end
            end
            if (free_push_ready_i) begin
                for (int j = 0; j < n; j++) void'(sb.pop_front());
                popped += n;
            end
        end
    end

    task automatic clear_bundle();
        retire_valid_i = '0; retire_rd_arch_i = '0;
        retire_rd_phys_i = '0; retire_old_phys_i = '0;
    endtask

    task automatic check_map(input string tag);
        for (int i = 0; i < 32; i++) begin
            total++;
            if (commit_map_o[7*i +: 7] !== exp_map[i]) begin
                bad++; $display("FAIL %s map[%0d] got=%0d exp=%0d", tag, i, commit_map_o[7*i +: 7], exp_map[i]);
            end
        end
    endtask

    // Applies the bundle currently on the inputs for one edge and updates the model if it fits.
    task automatic step_retire(output bit acc);
        acc = (sb.size() <= 8);
        total++;
        if (retire_ready_o !== acc) begin
            bad++; $display("FAIL step_ready got=%0b exp=%0b", retire_ready_o, acc);
        end
        @(posedge clk); #1;
        if (acc) begin
            for (int k = 0; k < 8; k++) begin
                if (retire_valid_i[k] && retire_rd_arch_i[k] != 0) begin
                    exp_map[retire_rd_arch_i[k]] = retire_rd_phys_i[k];
                    if (retire_old_phys_i[k] != 0) sb.push_back(retire_old_phys_i[k]);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain_all();
        free_push_ready_i = 1;
        for (int c = 0; c < 200 && sb.size() != 0; c++) idle(1);
        idle(1);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL drain_timeout left=%0d exp=0", sb.size());
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        rst = 1;
        clear_bundle();
        free_push_ready_i = 0;
        idle(2);
        rst = 0;
        sb.delete();
        popped = 0;
        for (int i = 0; i < 32; i++) exp_map[i] = 7'(i);
    endtask

    task automatic test_reset();
        do_reset();
        check_map("reset");
        total++;
        if (buf_count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", buf_count_o); end
        total++;
        if (free_push_valid_o !== 4'd0) begin bad++; $display("FAIL reset_valid got=%b exp=0000", free_push_valid_o); end
        total++;
        if (free_push_phys_o !== '0) begin bad++; $display("FAIL reset_phys got=%h exp=0", free_push_phys_o); end
        total++;
        if (retire_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", retire_ready_o); end
        mon_en = 1;
    endtask

    task automatic test_single();
        bit acc;
        free_push_ready_i = 1;
        clear_bundle();
        retire_valid_i[3] = 1; retire_rd_arch_i[3] = 5;
        retire_rd_phys_i[3] = 40; retire_old_phys_i[3] = 5;
        step_retire(acc);
        clear_bundle();
        total++;
        if (commit_map_o[35 +: 7] !== 7'd40) begin bad++; $display("FAIL single_map got=%0d exp=40", commit_map_o[35 +: 7]); end
        total++;
        if (buf_count_o !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", buf_count_o); end
        total++;
        if (free_push_valid_o !== 4'b0001) begin bad++; $display("FAIL single_valid got=%b exp=0001", free_push_valid_o); end
        total++;
        if (free_push_phys_o[0] !== 7'd5) begin bad++; $display("FAIL single_lane0 got=%0d exp=5", free_push_phys_o[0]); end
        idle(1);
        total++;
        if (buf_count_o !== 5'd0) begin bad++; $display("FAIL single_drained got=%0d exp=0", buf_count_o); end
    endtask

    task automatic test_full();
        bit acc;
        free_push_ready_i = 0;
        for (int b = 0; b < 3; b++) begin
            clear_bundle();
            for (int k = 0; k < 8; k++) begin
                retire_valid_i[k] = 1; retire_rd_arch_i[k] = 5'(k + 1);
                retire_rd_phys_i[k] = 7'((b == 2 ? 100 : 65) + k);
                retire_old_phys_i[k] = 7'(33 + k);
            end
            step_retire(acc);
            if (b == 0) begin
                total++;
                if (buf_count_o !== 5'd8 || free_push_phys_o !== {7'd36, 7'd35, 7'd34, 7'd33}) begin
                    bad++; $display("FAIL full_first count=%0d lanes=%h exp=8 and 33..36", buf_count_o, free_push_phys_o);
                end
            end
        end
        clear_bundle();
        total++;
        if (buf_count_o !== 5'd16 || retire_ready_o !== 1'b0) begin
            bad++; $display("FAIL full_stall count=%0d ready=%0b exp=16/0", buf_count_o, retire_ready_o);
        end
        total++;
        if (commit_map_o[7 +: 7] !== 7'd65) begin bad++; $display("FAIL full_ignored map[1] got=%0d exp=65", commit_map_o[7 +: 7]); end
        check_map("full");
        drain_all();
    endtask

    task automatic test_filter();
        bit acc;
        free_push_ready_i = 0;
        clear_bundle();
        retire_valid_i = 8'b0001_0101;
        retire_rd_arch_i[0] = 0;  retire_rd_phys_i[0] = 11; retire_old_phys_i[0] = 12;
        retire_rd_arch_i[2] = 7;  retire_rd_phys_i[2] = 20; retire_old_phys_i[2] = 0;
        retire_rd_arch_i[4] = 10; retire_rd_phys_i[4] = 21; retire_old_phys_i[4] = 77;
        retire_rd_arch_i[1] = 3;  retire_rd_phys_i[1] = 90; retire_old_phys_i[1] = 91;
        step_retire(acc);
        clear_bundle();
        total++;
        if (buf_count_o !== 5'd1 || free_push_phys_o[0] !== 7'd77) begin
            bad++; $display("FAIL filter count=%0d lane0=%0d exp=1/77", buf_count_o, free_push_phys_o[0]);
        end
        total++;
        if (commit_map_o[6:0] !== 7'd0 || commit_map_o[49 +: 7] !== 7'd20) begin
            bad++; $display("FAIL filter_map m0=%0d m7=%0d exp=0/20", commit_map_o[6:0], commit_map_o[49 +: 7]);
        end
        check_map("filter");
        drain_all();
    endtask

    task automatic test_collision();
        bit acc;
        free_push_ready_i = 0;
        clear_bundle();
        retire_valid_i = 8'b0100_0010;
        retire_rd_arch_i[1] = 9; retire_rd_phys_i[1] = 50; retire_old_phys_i[1] = 51;
        retire_rd_arch_i[6] = 9; retire_rd_phys_i[6] = 60; retire_old_phys_i[6] = 52;
        step_retire(acc);
        clear_bundle();
        total++;
        if (commit_map_o[63 +: 7] !== 7'd60) begin bad++; $display("FAIL collide_map got=%0d exp=60", commit_map_o[63 +: 7]); end
        total++;
        if (free_push_phys_o[1:0] !== {7'd52, 7'd51}) begin
            bad++; $display("FAIL collide_order got=%h exp=51 then 52", free_push_phys_o[1:0]);
        end
        drain_all();
    endtask

    task automatic test_mid_reset();
        bit acc;
        free_push_ready_i = 0;
        clear_bundle();
        retire_valid_i = 8'h0f;
        for (int k = 0; k < 4; k++) begin
            retire_rd_arch_i[k] = 5'(20 + k); retire_rd_phys_i[k] = 7'(110 + k); retire_old_phys_i[k] = 7'(60 + k);
        end
        step_retire(acc);
        free_push_ready_i = 1;
        do_reset();
        total++;
        if (buf_count_o !== 5'd0 || free_push_valid_o !== 4'd0) begin
            bad++; $display("FAIL midreset count=%0d valid=%b exp=0/0000", buf_count_o, free_push_valid_o);
        end
        check_map("midreset");
        mon_en = 1;
    endtask

    task automatic test_wrap();
        int sizes[9] = '{3, 5, 8, 3, 5, 8, 5, 8, 5};
        int pushed = 0;
        bit acc;
        do_reset();
        mon_en = 1;
        foreach (sizes[b]) begin
            clear_bundle();
            for (int k = 0; k < sizes[b]; k++) begin
                retire_valid_i[k] = 1;
                retire_rd_arch_i[k] = 5'($urandom_range(1, 31));
                retire_rd_phys_i[k] = 7'($urandom_range(0, 127));
                retire_old_phys_i[k] = 7'($urandom_range(1, 127));
            end
            acc = 0;
            for (int t = 0; t < 60 && !acc; t++) begin
                free_push_ready_i = 1'($urandom_range(0, 1));
                step_retire(acc);
            end
            total++;
            if (!acc) begin bad++; $display("FAIL wrap_accept_timeout bundle=%0d exp=accepted", b); end
            else pushed += sizes[b];
            clear_bundle();
        end
        drain_all();
        total++;
        if (popped !== 50 || pushed !== 50) begin
            bad++; $display("FAIL wrap_total popped=%0d pushed=%0d exp=50", popped, pushed);
        end
        check_map("wrap");
`ifdef COMMIT_RECLAIM_STATS_EN
        total++;
        if (stat_reclaimed_o !== 32'd50) begin bad++; $display("FAIL stat_reclaimed got=%0d exp=50", stat_reclaimed_o); end
`endif
    endtask

    initial begin
        clear_bundle();
        rst = 1;
        free_push_ready_i = 0;
        test_reset();
        test_single();
        test_full();
        test_filter();
        test_collision();
        test_mid_reset();
        test_wrap();
        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/commit_reclaim_8wide.md
Name: commit_reclaim_8wide

Overview:
- Retire-side counterpart to the 8-wide rename stage.
- Accepts up to 8 retiring instructions per cycle from the ROB and maintains the committed (architectural) arch-to-phys map.
- Queues each displaced old physical register in a staging FIFO.
- Drains the FIFO back to the rename free list at up to DRAIN_WIDTH registers per cycle, under ready/valid backpressure.

Parameters:
- PHYS_REGS, 128, number of physical registers; phys tag width is 7.
- ARCH_REGS, 32, number of architectural registers; arch index width is 5.
- BUF_DEPTH, 16, staging FIFO entries; must be a power of 2 and at least 8.
- DRAIN_WIDTH, 4, maximum tags returned to the free list per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- retire_valid_i  in  8  per-slot retire valid; slot 0 is oldest.
- retire_rd_arch_i  in  5 x8  destination architectural register per slot.
- retire_rd_phys_i  in  7 x8  new physical register per slot.
- retire_old_phys_i  in  7 x8  displaced physical register per slot.
- retire_ready_o  out  1  bundle accepted this cycle when high.
- commit_map_o  out  ARCH_REGS*7  committed map, flattened; entry i occupies bits [7i+6:7i].
- free_push_valid_o  out  DRAIN_WIDTH  thermometer mask of tags offered to the free list.
- free_push_phys_o  out  7 x DRAIN_WIDTH  offered tags; lane 0 is the oldest.
- free_push_ready_i  in  1  free list accepts all offered lanes.
- buf_count_o  out  $clog2(BUF_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, with rst high at a clock edge:
  - commit map entry i = i.
  - FIFO head, tail and count = 0.
  - free_push_valid_o = 0; free_push_phys_o = 0; buf_count_o = 0.
  - Reset mid-operation discards all queued tags. No partial drain or map update occurs that cycle.
- retire_ready_o is combinational from registered count: high iff BUF_DEPTH - count >= 8. It does not depend on retire_valid_i or on the same-cycle drain.
- Accept:
  - Occurs when retire_ready_o is high.
  - If retire_ready_o is low, the bundle is ignored entirely (no map update, no push). The ROB holds the bundle.
- Slot qualification: a slot is live iff retire_valid_i[k] is set and retire_rd_arch_i[k] != 0.
- Map update:
  - For each live slot in ascending k, commit_map[rd_arch] <= rd_phys.
  - The highest live slot writing the same arch register wins.
  - Visible on commit_map_o the next cycle.
- Reclaim push:
  - Each live slot with old_phys != 0 is pushed at tail, compacted in ascending slot order with no holes.
  - tail += number pushed, mod BUF_DEPTH.
  - Non-live slots and tag 0 are never pushed.
- Drain presentation:
  - n = min(count, DRAIN_WIDTH).
  - free_push_valid_o = (1<<n)-1.
  - Lane j carries fifo[(head+j) mod BUF_DEPTH].
  - Invalid lanes drive 0.
  - All drain outputs derive from registered state only.
- Drain pop:
  - If free_push_ready_i is high and n > 0, head += n and count -= n.
  - If free_push_ready_i is low, nothing pops and the lanes hold their values.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped.
- A tag accepted at cycle N is offered no earlier than N+1.
- Pointers wrap naturally; count never exceeds BUF_DEPTH, and the ready rule guarantees this.
- There is no flush input: committed state is non-speculative and survives pipeline flushes.

Optional Feature:
- Macro: COMMIT_RECLAIM_STATS_EN.
- When defined, three extra outputs are added:
  - stat_reclaimed_o, 32 bits: total tags popped to the free list.
  - stat_stall_o, 32 bits: cycles with any retire_valid_i set while retire_ready_o is low.
  - stat_backpress_o, 32 bits: cycles with count > 0 while free_push_ready_i is low.
- All three counters wrap, reset to 0 on rst, and update on the same edge as the event.
- When undefined, these ports and counters do not exist. Functional behaviour is identical in both builds.

Test Plan:
1. Reset -> commit_map_o entry i = i for all 32; buf_count_o = 0; free_push_valid_o = 0; retire_ready_o = 1.
2. Single retire, slot 3 valid, rd_arch = 5, rd_phys = 40, old_phys = 5, free_push_ready_i = 1 -> next cycle map[5] = 40, buf_count_o = 1, free_push_valid_o = 4'b0001, lane 0 = 5; following cycle buf_count_o = 0.
3. Full bundle, slots 0-7 valid, rd_arch = 1..8, old_phys = 33..40, free_push_ready_i = 0 -> buf_count_o = 8 and lanes show 33,34,35,36. Second identical bundle -> count 16 and retire_ready_o = 0. Third bundle -> ignored, map unchanged. Raise ready -> 4 pops per cycle in order 33..40 then repeat; retire_ready_o returns high once count <= 8.
4. Filtering, slots {0,2,4} valid: slot 0 rd_arch = 0, slot 2 old_phys = 0, slot 4 old_phys = 77 -> only 77 pushed; map[0] stays 0; slot 2 map update still applied.
5. Same-arch collision: slots 1 and 6 both rd_arch = 9, rd_phys 50 and 60 -> map[9] = 60; both old tags pushed, slot 1's first.
6. Wrap: push and drain 50 tags in mixed 3/5/8 bundles with random free_push_ready_i -> popped sequence equals pushed sequence exactly; count never exceeds 16; with COMMIT_RECLAIM_STATS_EN, stat_reclaimed_o = 50.
